// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern modes, default 640x480 timing geometry and colours.
package vga_pkg;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    BOX     = 2'd2,
    BORDER  = 2'd3
  } mode_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Box-pattern background: blue only.
  localparam int unsigned BG_COLOUR = 1;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// One axis of the bouncing box: position and direction, stepped once per frame tick.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int unsigned active = 640,
  parameter int unsigned size   = 32,
  parameter int unsigned step   = 2,
  parameter int unsigned width  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  output logic [width-1:0] pos,
  output logic             dir
);

  localparam int unsigned W1 = width + 1;
  localparam logic [W1-1:0] LIM  = W1'(active - size);
  localparam logic [W1-1:0] STEP = W1'(step);

  logic [W1-1:0] pos_ext;
  assign pos_ext = W1'(pos);

  // dir = 0 moves towards lim, dir = 1 moves towards 0; both ends clamp then reverse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos <= '0;
      dir <= 1'b0;
    end else if (tick) begin
      if (!dir) begin
        if (pos_ext + STEP >= LIM) begin
          pos <= LIM[width-1:0];
          dir <= 1'b1;
        end else begin
          pos <= pos + STEP[width-1:0];
        end
      end else begin
        if (pos_ext <= STEP) begin
          pos <= '0;
          dir <= 1'b0;
        end else begin
          pos <= pos - STEP[width-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: four patterns selected by a button, switched only on frame boundaries.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned data_width = 3,
  parameter int unsigned h_width    = 10,
  parameter int unsigned v_width    = 10,
  parameter int unsigned h_active   = H_ACTIVE,
  parameter int unsigned v_active   = V_ACTIVE,
  parameter int unsigned box_size   = 32,
  parameter int unsigned step       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [h_width-1:0]    h_count,
  input  logic [v_width-1:0]    v_count,
  input  logic                  mode_next,
  output logic [data_width-1:0] data_out,
  output logic [1:0]            mode
);

  localparam int unsigned HW1 = h_width + 1;
  localparam int unsigned VW1 = v_width + 1;
  localparam int unsigned BAR_W = h_active / 8;

  localparam logic [h_width-1:0] H_ACT  = h_width'(h_active);
  localparam logic [v_width-1:0] V_ACT  = v_width'(v_active);
  localparam logic [h_width-1:0] H_LAST = h_width'(h_active - 1);
  localparam logic [v_width-1:0] V_LAST = v_width'(v_active - 1);

  mode_t                  mode_q;
  logic                   sync_q, sync_qq, edge_q;
  logic                   pending;
  logic                   rise;
  logic                   frame_tick;
  logic                   active;
  logic [h_width-1:0]     box_x;
  logic [v_width-1:0]     box_y;
  logic                   dir_x, dir_y;
  logic                   unused_dirs;
  logic                   in_box;
  logic                   on_border;
  logic [2:0]             bar_idx;
  logic [data_width-1:0]  pix;

  assign mode        = mode_q;
  assign frame_tick  = (h_count == '0) && (v_count == V_ACT);
  assign active      = (h_count < H_ACT) && (v_count < V_ACT);
  assign rise        = sync_qq & ~edge_q;
  assign unused_dirs = ^{dir_x, dir_y};

  vga_box_mover #(
    .active (h_active),
    .size   (box_size),
    .step   (step),
    .width  (h_width)
  ) u_box_x (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (frame_tick),
    .pos   (box_x),
    .dir   (dir_x)
  );

  vga_box_mover #(
    .active (v_active),
    .size   (box_size),
    .step   (step),
    .width  (v_width)
  ) u_box_y (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (frame_tick),
    .pos   (box_y),
    .dir   (dir_y)
  );

  // Box extents computed one bit wider so box_x + box_size cannot wrap.
  assign in_box = (h_count >= box_x) && (HW1'(h_count) < HW1'(box_x) + HW1'(box_size)) &&
                  (v_count >= box_y) && (VW1'(v_count) < VW1'(box_y) + VW1'(box_size));

  assign on_border = (h_count == '0) || (h_count == H_LAST) ||
                     (v_count == '0) || (v_count == V_LAST);

  always_comb begin
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_count >= h_width'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  always_comb begin
    pix = '0;
    if (active) begin
      unique case (mode_q)
        BARS:    pix = data_width'(bar_idx);
        CHECKER: pix = {data_width{h_count[5] ^ v_count[5]}};
        BOX:     pix = in_box ? '1 : data_width'(BG_COLOUR);
        BORDER:  pix = on_border ? '1 : '0;
        default: pix = '0;
      endcase
    end
  end

  // A rise coinciding with frame_tick is honoured directly so it is not deferred a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      sync_qq  <= 1'b0;
      edge_q   <= 1'b0;
      pending  <= 1'b0;
      mode_q   <= BARS;
      data_out <= '0;
    end else begin
      sync_q   <= mode_next;
      sync_qq  <= sync_q;
      edge_q   <= sync_qq;
      data_out <= pix;
      if (frame_tick) begin
        if (pending || rise) mode_q <= next_mode(mode_q);
        pending <= 1'b0;
      end else if (rise) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: driver pushes model predictions, monitor compares each cycle.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_next = 1'b0;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic [2:0] data_out;
  logic [1:0] mode;

  vga_pattern_gen #(
    .data_width (3),
    .h_width    (10),
    .v_width    (10),
    .h_active   (640),
    .v_active   (480),
    .box_size   (32),
    .step       (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_count   (h_count),
    .v_count   (v_count),
    .mode_next (mode_next),
    .data_out  (data_out),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] d;
    logic [1:0] m;
    string      name;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  int m_x = 0, m_y = 0, m_mode = 0;
  bit m_dx = 0, m_dy = 0, m_pend = 0;
  bit hist[3] = '{0, 0, 0};

  function automatic int colour(input int h, input int v);
    if (h >= 640 || v >= 480) return 0;
    case (m_mode)
      0: return (h / 80) % 8;
      1: return (((h / 32) + (v / 32)) % 2 == 1) ? 7 : 0;
      2: return (h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32) ? 7 : 1;
      default: return (h == 0 || h == 639 || v == 0 || v == 479) ? 7 : 0;
    endcase
  endfunction

  function automatic void move(input int lim, inout int pos, inout bit back);
    if (!back) begin
      if (pos + 2 >= lim) begin pos = lim; back = 1; end
      else pos = pos + 2;
    end else begin
      if (pos <= 2) begin pos = 0; back = 0; end
      else pos = pos - 2;
    end
  endfunction

  function automatic int model_step(input int h, input int v, input bit mn, input bit r);
    int d;
    bit rise, tick;
    if (!r) begin
      m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_mode = 0; m_pend = 0;
      hist = '{0, 0, 0};
      return 0;
    end
    d = colour(h, v);
    tick = (h == 0 && v == 480);
    // Button edge is seen when the sample from two edges ago is high and three edges ago was low.
    rise = hist[1] && !hist[2];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = mn;
    if (tick) begin
      move(608, m_x, m_dx);
      move(448, m_y, m_dy);
      if (m_pend || rise) m_mode = (m_mode + 1) % 4;
      m_pend = 0;
    end else if (rise) begin
      m_pend = 1;
    end
    return d;
  endfunction

  task automatic cyc(input int h, input int v, input bit mn, input bit r,
                     input string name = "rand", input int dd = -1, input int dm = -1);
    exp_t e;
    int md;
    h_count = 10'(h); v_count = 10'(v); mode_next = mn; rst_n = r;
    @(posedge clk);
    md = model_step(h, v, mn, r);
    e.d = (dd >= 0) ? 3'(dd) : 3'(md);
    e.m = (dm >= 0) ? 2'(dm) : 2'(m_mode);
    e.name = name;
    sb.push_back(e);
    #1;
  endtask

  task automatic tick(input string name = "tick", input int dm = -1);
    cyc(0, 480, 0, 1, name, -1, dm);
  endtask

  task automatic pulse();
    cyc($urandom_range(0, 639), $urandom_range(0, 479), 1, 1);
    cyc($urandom_range(0, 639), $urandom_range(0, 479), 1, 1);
    cyc($urandom_range(0, 639), $urandom_range(0, 479), 0, 1);
    cyc($urandom_range(0, 639), $urandom_range(0, 479), 0, 1);
  endtask

  task automatic rand_cycles(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      if (m_mode == 2 && $urandom_range(0, 1) == 1) begin
        h = ((m_x > 0) ? m_x - 1 : 0) + $urandom_range(0, 33);
        v = ((m_y > 0) ? m_y - 1 : 0) + $urandom_range(0, 33);
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      if (h == 0 && v == 480) v = 0;
      cyc(h, v, 0, 1);
    end
  endtask

  // Monitor: the DUT presents a pixel every cycle, so each expectation is consumed on the next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (data_out !== e.d) begin
          n_err++;
          $display("FAIL %s data_out: got %0d expected %0d", e.name, data_out, e.d);
        end
        n_cmp++;
        if (mode !== e.m) begin
          n_err++;
          $display("FAIL %s mode: got %0d expected %0d", e.name, mode, e.m);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bar_h[6] = '{0, 79, 80, 400, 639, 640};
    int bar_e[6] = '{0, 0, 1, 5, 7, 0};

    for (int i = 0; i < 4; i++) cyc(i * 150, i * 100, 0, 0, "reset", 0, 0);
    for (int i = 0; i < 6; i++) cyc(bar_h[i], 10, 0, 1, "bars", bar_e[i], 0);
    rand_cycles(40);

    repeat (3) pulse();
    rand_cycles(3);
    tick("three_pulses_one_step", 1);
    rand_cycles(5);
    tick("no_extra_step", 1);

    cyc(31, 0, 0, 1, "checker_31_0", 0, 1);
    cyc(32, 0, 0, 1, "checker_32_0", 7, 1);
    cyc(32, 32, 0, 1, "checker_32_32", 0, 1);
    rand_cycles(40);

    cyc(100, 100, 1, 1, "pre_edge");
    cyc(101, 100, 1, 1, "pre_edge");
    cyc(0, 480, 1, 1, "edge_on_tick", -1, 2);
    cyc(0, 480, 1, 1, "held_no_step", -1, 2);
    cyc(5, 5, 0, 1);
    rand_cycles(60);

    pulse();
    tick("to_border", 3);
    cyc(0, 100, 0, 1, "border_0_100", 7, 3);
    cyc(1, 100, 0, 1, "border_1_100", 0, 3);
    cyc(639, 479, 0, 1, "border_639_479", 7, 3);
    rand_cycles(30);
    pulse();
    tick("wrap", 0);

    cyc(50, 50, 0, 0, "reset2", 0, 0);
    pulse(); tick("adv1", 1);
    pulse(); tick("adv2", 2);
    for (int i = 0; i < 48; i++) tick();
    cyc(100, 100, 0, 1, "box100_in", 7, 2);
    cyc(99, 100, 0, 1, "box100_left", 1, 2);
    cyc(131, 131, 0, 1, "box100_corner", 7, 2);
    cyc(132, 100, 0, 1, "box100_right", 1, 2);

    cyc(110, 110, 0, 0, "midframe_reset", 0, 0);
    cyc(4, 4, 0, 1, "after_reset_mode0", 0, 0);
    pulse(); tick("readv1", 1);
    pulse(); tick("readv2", 2);
    cyc(4, 4, 0, 1, "restart_in", 7, 2);
    cyc(3, 4, 0, 1, "restart_left", 1, 2);
    cyc(35, 35, 0, 1, "restart_corner", 7, 2);
    cyc(36, 35, 0, 1, "restart_right", 1, 2);

    for (int i = 0; i < 302; i++) tick();
    cyc(608, 300, 0, 1, "bounce_608_in", 7, 2);
    cyc(607, 300, 0, 1, "bounce_607_out", 1, 2);
    cyc(639, 319, 0, 1, "bounce_corner", 7, 2);
    cyc(608, 287, 0, 1, "bounce_y_above", 1, 2);
    cyc(608, 288, 0, 1, "bounce_y_top", 7, 2);
    tick("bounce_back", 2);
    cyc(606, 286, 0, 1, "back_606_in", 7, 2);
    cyc(605, 286, 0, 1, "back_605_out", 1, 2);
    cyc(637, 317, 0, 1, "back_corner", 7, 2);
    cyc(638, 300, 0, 1, "back_right", 1, 2);
    rand_cycles(40);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
